// File: rtl/reset_sequencer.sv
// Power-on / push-button reset sequencer for a DCM-clocked system.
// Pulses DCM reset, waits for lock (with retry), holds system reset until lock is stable.
module reset_sequencer #(
    parameter int DCM_RST_CYCLES  = 4,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int HOLD_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dcm_locked,
    input  logic       button,
    output logic       dcm_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [1:0] state,
    output logic [3:0] retry_count
);

    typedef enum logic [1:0] {
        S_DCM_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam int MAX_A = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);
    localparam int DBW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0]  C_DCM_LAST  = CW'(DCM_RST_CYCLES - 1);
    localparam logic [CW-1:0]  C_LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]  C_HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [DBW-1:0] C_DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     r_lk_sync, r_bt_sync;
    logic [DBW-1:0] r_db_cnt;
    logic           r_db_lvl, r_db_lvl_d;
    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt, w_cnt_inc;
    logic           w_lk, w_bt, w_press, w_timeout;
    logic           r_dcm_reset, r_sys_reset, r_ready;
    logic [3:0]     r_retry;

    assign w_lk = r_lk_sync[1];
    assign w_bt = r_bt_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lk_sync <= '0;
            r_bt_sync <= '0;
        end else begin
            r_lk_sync <= {r_lk_sync[0], dcm_locked};
            r_bt_sync <= {r_bt_sync[0], button};
        end
    end

    // Level flips only after DEBOUNCE_CYCLES samples in a row disagreeing with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt   <= '0;
            r_db_lvl   <= 1'b0;
            r_db_lvl_d <= 1'b0;
        end else begin
            r_db_lvl_d <= r_db_lvl;
            if (w_bt == r_db_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == C_DB_LAST) begin
                r_db_cnt <= '0;
                r_db_lvl <= w_bt;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press   = r_db_lvl & ~r_db_lvl_d;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_DCM_RST:   if (r_cnt == C_DCM_LAST) w_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_lk) begin
                    w_next = S_HOLD;
                end else if (r_cnt == C_LOCK_LAST) begin
                    w_next    = S_DCM_RST;
                    w_timeout = 1'b1;
                end
            end
            S_HOLD: begin
                if (!w_lk)                     w_next = S_DCM_RST;
                else if (r_cnt == C_HOLD_LAST) w_next = S_RUN;
            end
            S_RUN: begin
                // Lock loss outranks a simultaneous button press.
                if (!w_lk)        w_next = S_DCM_RST;
                else if (w_press) w_next = S_HOLD;
            end
            default:     w_next = S_DCM_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_DCM_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_dcm_reset <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= (w_next != r_state) ? '0 : w_cnt_inc;
            if (w_timeout && r_retry != 4'hF) r_retry <= r_retry + 1'b1;
            r_dcm_reset <= (w_next == S_DCM_RST);
            r_sys_reset <= (w_next != S_RUN);
            r_ready     <= (w_next == S_RUN);
        end
    end

    assign state       = r_state;
    assign retry_count = r_retry;
    assign dcm_reset   = r_dcm_reset;
    assign sys_reset   = r_sys_reset;
    assign ready       = r_ready;

endmodule
